// File: rtl/bomb_controller_if.sv
// Bundle of request/pixel inputs and layer/status outputs for bomb_controller.
// The master side drives player, button and VGA position; the slave side is the controller.
interface bomb_controller_if #(
    parameter int TILE_BITS = 5
);
    localparam int TW = 10 - TILE_BITS;

    logic          C;
    logic [9:0]    b_x;
    logic [9:0]    b_y;
    logic          game_over;
    logic [9:0]    v_x;
    logic [9:0]    v_y;
    logic          bomb_on;
    logic [11:0]   bomb_rgb;
    logic          explosion_on;
    logic [11:0]   explosion_rgb;
    logic          bomb_active;
    logic [TW-1:0] bomb_tile_x;
    logic [TW-1:0] bomb_tile_y;
    logic          explode_pulse;
    logic          bomberman_hit;

    modport master (
        output C, b_x, b_y, game_over, v_x, v_y,
        input  bomb_on, bomb_rgb, explosion_on, explosion_rgb, bomb_active,
        input  bomb_tile_x, bomb_tile_y, explode_pulse, bomberman_hit
    );

    modport slave (
        input  C, b_x, b_y, game_over, v_x, v_y,
        output bomb_on, bomb_rgb, explosion_on, explosion_rgb, bomb_active,
        output bomb_tile_x, bomb_tile_y, explode_pulse, bomberman_hit
    );
endinterface

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle (IDLE -> ARMED -> EXPLODING) with registered pixel-layer outputs.
// Optional macro BOMB_BLINK_EN makes the bomb flash white late in the fuse.
module bomb_controller #(
    parameter int          TILE_BITS      = 5,
    parameter int          FUSE_CYCLES    = 200_000_000,
    parameter int          EXPLODE_CYCLES = 50_000_000,
    parameter int          BLAST_RANGE    = 2,
    parameter logic [11:0] BOMB_COLOR     = 12'h333,
    parameter logic [11:0] FIRE_COLOR     = 12'hF80
) (
    input  logic sys_clk,
    input  logic Reset,
    bomb_controller_if.slave bus
);
    localparam int TW   = 10 - TILE_BITS;
    localparam int MAXC = (FUSE_CYCLES > EXPLODE_CYCLES) ? FUSE_CYCLES : EXPLODE_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] RANGE = TW'(BLAST_RANGE);
    localparam logic [10:0]   HALF  = 11'(1 << (TILE_BITS - 1));

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EXPLODING} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_latch, w_pulse_nxt;
    logic [TW-1:0] r_tile_x, r_tile_y;
    logic          r_bomb_on, r_expl_on, r_pulse, r_hit;
    logic [TW-1:0] w_px, w_py, w_ptx, w_pty;

    function automatic logic [TW-1:0] absdiff(input logic [TW-1:0] a, input logic [TW-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic in_cross(input logic [TW-1:0] dx, input logic [TW-1:0] dy);
        return (dy == '0 && dx <= RANGE) || (dx == '0 && dy <= RANGE);
    endfunction

    // Player tile uses centre rounding; the 11-bit sum keeps the carry out of b_x.
    assign w_ptx = TW'(({1'b0, bus.b_x} + HALF) >> TILE_BITS);
    assign w_pty = TW'(({1'b0, bus.b_y} + HALF) >> TILE_BITS);
    assign w_px  = TW'(bus.v_x >> TILE_BITS);
    assign w_py  = TW'(bus.v_y >> TILE_BITS);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_pulse_nxt = 1'b0;
        if (bus.game_over) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.C) begin
                    w_state_nxt = S_ARMED;
                    w_cnt_nxt   = CW'(FUSE_CYCLES - 1);
                    w_latch     = 1'b1;
                end
                S_ARMED: if (r_cnt == '0) begin
                    w_state_nxt = S_EXPLODING;
                    w_cnt_nxt   = CW'(EXPLODE_CYCLES - 1);
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                S_EXPLODING: if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tile_x  <= '0;
            r_tile_y  <= '0;
            r_pulse   <= 1'b0;
            r_bomb_on <= 1'b0;
            r_expl_on <= 1'b0;
            r_hit     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            if (w_latch) begin
                r_tile_x <= w_ptx;
                r_tile_y <= w_pty;
            end
            r_bomb_on <= (r_state == S_ARMED) && absdiff(w_px, r_tile_x) == '0
                         && absdiff(w_py, r_tile_y) == '0;
            r_expl_on <= (r_state == S_EXPLODING)
                         && in_cross(absdiff(w_px, r_tile_x), absdiff(w_py, r_tile_y));
            r_hit     <= (r_state == S_EXPLODING)
                         && in_cross(absdiff(w_ptx, r_tile_x), absdiff(w_pty, r_tile_y));
        end
    end

    assign bus.bomb_on       = r_bomb_on;
    assign bus.explosion_on  = r_expl_on;
    assign bus.explosion_rgb = FIRE_COLOR;
    assign bus.bomb_active   = (r_state != S_IDLE);
    assign bus.bomb_tile_x   = r_tile_x;
    assign bus.bomb_tile_y   = r_tile_y;
    assign bus.explode_pulse = r_pulse;
    assign bus.bomberman_hit = r_hit;

`ifdef BOMB_BLINK_EN
    // Blink phase flips on each falling edge of the chosen counter bit (bit 22 at full size).
    localparam int BLINK_BIT = (CW > 22) ? 22 : CW - 1;
    logic        r_blink, r_bit_q;
    logic [11:0] r_bomb_rgb;

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            r_blink    <= 1'b0;
            r_bit_q    <= 1'b0;
            r_bomb_rgb <= BOMB_COLOR;
        end else begin
            r_bit_q <= r_cnt[BLINK_BIT];
            if (r_state != S_ARMED)
                r_blink <= 1'b0;
            else if (r_bit_q && !r_cnt[BLINK_BIT])
                r_blink <= ~r_blink;
            r_bomb_rgb <= (r_state == S_ARMED && r_cnt < CW'(FUSE_CYCLES / 4) && r_blink)
                          ? 12'hFFF : BOMB_COLOR;
        end
    end

    assign bus.bomb_rgb = r_bomb_rgb;
`else
    assign bus.bomb_rgb = BOMB_COLOR;
`endif
endmodule

// File: tb/tb_bomb_controller.sv
// Directed/randomised bench for bomb_controller against a timestamp-based lifecycle model.
// The model tracks drop time and derives phase from elapsed cycles.
module tb_bomb_controller;
    localparam int FUSE = 20;
    localparam int EXPL = 8;
    localparam int RNG  = 2;

    logic sys_clk = 1'b0;
    logic Reset   = 1'b1;

    bomb_controller_if #(.TILE_BITS(5)) bus();

    bomb_controller #(
        .TILE_BITS(5), .FUSE_CYCLES(FUSE), .EXPLODE_CYCLES(EXPL), .BLAST_RANGE(RNG),
        .BOMB_COLOR(12'h333), .FIRE_COLOR(12'hF80)
    ) dut (
        .sys_clk(sys_clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit m_active = 1'b0;
    int m_drop   = 0;
    int m_tx     = 0;
    int m_ty     = 0;

    // 0 idle, 1 armed, 2 exploding, from cycles elapsed since the accepted drop
    function automatic int phase();
        int age;
        if (!m_active) return 0;
        age = cyc - m_drop;
        if (age < FUSE) return 1;
        if (age < FUSE + EXPL) return 2;
        return 0;
    endfunction

    function automatic bit in_cross(int px, int py, int tx, int ty);
        int dx, dy;
        dx = (px > tx) ? px - tx : tx - px;
        dy = (py > ty) ? py - ty : ty - py;
        return (dy == 0 && dx <= RNG) || (dx == 0 && dy <= RNG);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        int ph, age, vtx, vty, ptx, pty;
        bit e_bomb, e_expl, e_hit, e_pulse;
        ph  = phase();
        age = cyc - m_drop;
        vtx = int'(bus.v_x) / 32;
        vty = int'(bus.v_y) / 32;
        ptx = (int'(bus.b_x) + 16) / 32;
        pty = (int'(bus.b_y) + 16) / 32;
        e_bomb  = (ph == 1) && vtx == m_tx && vty == m_ty;
        e_expl  = (ph == 2) && in_cross(vtx, vty, m_tx, m_ty);
        e_hit   = (ph == 2) && in_cross(ptx, pty, m_tx, m_ty);
        e_pulse = (ph == 1) && age == FUSE - 1 && !bus.game_over;
        if (bus.game_over) begin
            m_active = 1'b0;
        end else if (ph == 0 && bus.C) begin
            m_active = 1'b1;
            m_drop   = cyc + 1;
            m_tx     = ptx;
            m_ty     = pty;
        end
        @(posedge sys_clk);
        cyc++;
        #1;
        chk("bomb_active", 32'(bus.bomb_active), 32'(phase() != 0));
        chk("bomb_tile_x", 32'(bus.bomb_tile_x), 32'(m_tx));
        chk("bomb_tile_y", 32'(bus.bomb_tile_y), 32'(m_ty));
        chk("explode_pulse", 32'(bus.explode_pulse), 32'(e_pulse));
        chk("bomb_on", 32'(bus.bomb_on), 32'(e_bomb));
        chk("explosion_on", 32'(bus.explosion_on), 32'(e_expl));
        chk("bomberman_hit", 32'(bus.bomberman_hit), 32'(e_hit));
        chk("bomb_rgb", 32'(bus.bomb_rgb), 32'h333);
        chk("explosion_rgb", 32'(bus.explosion_rgb), 32'hF80);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_active"}, 32'(bus.bomb_active), 32'd0);
        chk({pfx, "_tile_x"}, 32'(bus.bomb_tile_x), 32'd0);
        chk({pfx, "_tile_y"}, 32'(bus.bomb_tile_y), 32'd0);
        chk({pfx, "_pulse"}, 32'(bus.explode_pulse), 32'd0);
        chk({pfx, "_bomb_on"}, 32'(bus.bomb_on), 32'd0);
        chk({pfx, "_expl_on"}, 32'(bus.explosion_on), 32'd0);
        chk({pfx, "_hit"}, 32'(bus.bomberman_hit), 32'd0);
        chk({pfx, "_bomb_rgb"}, 32'(bus.bomb_rgb), 32'h333);
        chk({pfx, "_expl_rgb"}, 32'(bus.explosion_rgb), 32'hF80);
    endtask

    initial begin
        int act, pulses, pidx;
        int edge_tx[5];
        int edge_ty[5];
        edge_tx = '{0, 1, 2, 3, 19};
        edge_ty = '{0, 1, 2, 3, 14};
        bus.C = 1'b0; bus.game_over = 1'b0;
        bus.b_x = '0; bus.b_y = '0; bus.v_x = '0; bus.v_y = '0;

        // reset state
        #12;
        chk_reset_outputs("rst");
        @(negedge sys_clk);
        Reset = 1'b0;

        // drop and full lifecycle at b=(100,100)
        bus.b_x = 10'd100; bus.b_y = 10'd100; bus.C = 1'b1;
        tick();
        bus.C = 1'b0;
        chk("drop_tile_x", 32'(bus.bomb_tile_x), 32'd3);
        chk("drop_tile_y", 32'(bus.bomb_tile_y), 32'd3);
        act = int'(bus.bomb_active); pulses = 0; pidx = 0;
        for (int k = 2; k <= 32; k++) begin
            bus.v_x = 10'($urandom_range(0, 639));
            bus.v_y = 10'($urandom_range(0, 479));
            tick();
            if (bus.bomb_active) act++;
            if (bus.explode_pulse) begin pulses++; pidx = k; end
        end
        chk("life_active_cycles", 32'(act), 32'd28);
        chk("pulse_count", 32'(pulses), 32'd1);
        chk("pulse_cycle", 32'(pidx), 32'd21);

        // frame sweep by tile, redropping whenever idle
        for (int s = 0; s < 900; s++) begin
            bus.C   = (phase() == 0);
            bus.v_x = 10'((s % 20) * 32 + int'($urandom_range(0, 31)));
            bus.v_y = 10'(((s / 20) % 15) * 32 + int'($urandom_range(0, 31)));
            tick();
        end
        bus.C = 1'b0;
        repeat (30) tick();

        // edge clipping at tile (0,0)
        bus.b_x = '0; bus.b_y = '0; bus.C = 1'b1;
        tick();
        bus.C = 1'b0;
        chk("edge_tile_x", 32'(bus.bomb_tile_x), 32'd0);
        for (int k = 0; k < 60; k++) begin
            bus.v_x = 10'(edge_tx[$urandom_range(0, 4)] * 32 + int'($urandom_range(0, 31)));
            bus.v_y = 10'(edge_ty[$urandom_range(0, 4)] * 32 + int'($urandom_range(0, 31)));
            tick();
            if (phase() == 0) begin bus.C = 1'b1; tick(); bus.C = 1'b0; end
        end
        repeat (30) tick();

        // ignored requests: armed, exploding, last exploding cycle; first idle accepted
        bus.b_x = 10'd100; bus.b_y = 10'd100; bus.C = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            bus.C   = (k == 5 || k == 24 || k == 28 || k == 29);
            bus.b_x = 10'($urandom_range(0, 600));
            bus.b_y = 10'($urandom_range(0, 460));
            bus.v_x = 10'($urandom_range(0, 639));
            bus.v_y = 10'($urandom_range(0, 479));
            tick();
            if (k == 28) chk("no_relatch_x", 32'(bus.bomb_tile_x), 32'd3);
            if (k == 29) chk("first_idle_accept", 32'(bus.bomb_active), 32'd1);
        end
        bus.C = 1'b0;
        repeat (30) tick();

        // hit, then game over
        bus.b_x = 10'd100; bus.b_y = 10'd100; bus.C = 1'b1;
        tick();
        bus.C = 1'b0; bus.b_x = 10'd128; bus.b_y = 10'd100;
        repeat (FUSE + 2) tick();
        chk("hit_tile_4_3", 32'(bus.bomberman_hit), 32'd1);
        bus.game_over = 1'b1;
        tick();
        chk("go_idle", 32'(bus.bomb_active), 32'd0);
        bus.C = 1'b1;
        tick();
        chk("go_blocks_drop", 32'(bus.bomb_active), 32'd0);
        bus.C = 1'b0; bus.game_over = 1'b0;
        repeat (3) tick();

        // asynchronous reset mid-fuse
        bus.b_x = 10'd300; bus.b_y = 10'd200; bus.C = 1'b1;
        tick();
        bus.C = 1'b0;
        repeat (5) tick();
        #3 Reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        m_active = 1'b0; m_tx = 0; m_ty = 0;
        #2 Reset = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
# bomb_controller

Single-bomb lifecycle engine for the Bomberman game. It latches a bomb at the player's tile on a debounced center-button pulse and runs a fuse timer, then an explosion window, then returns to idle. It emits per-pixel bomb and explosion layer enables and colours, which feed the top-level priority RGB mux alongside the VGA display controller's pixel counters. It also flags explosion contact with the player and broadcasts the blast for downstream wall logic.

## Interface
- TILE_BITS, 5, log2 of tile edge in pixels (32 px tiles); tile index width TW = 10-TILE_BITS
- FUSE_CYCLES, 200_000_000, sys_clk cycles spent in ARMED (2 s at 100 MHz)
- EXPLODE_CYCLES, 50_000_000, sys_clk cycles spent in EXPLODING
- BLAST_RANGE, 2, explosion arm length in tiles, excluding the centre tile
- BOMB_COLOR, 12'h333, bomb_rgb value
- FIRE_COLOR, 12'hF80, explosion_rgb value
- Clock and reset: the clock is sys_clk; Reset is asynchronous and active-high.

Ports:
- sys_clk  in  1  system clock, 100 MHz
- Reset  in  1  asynchronous, active-high
- C  in  1  debounced center-button single-cycle pulse; drop request
- b_x, b_y  in  10 each  player sprite top-left pixel position
- game_over  in  1  level; freezes the block
- v_x, v_y  in  10 each  current VGA pixel (hCount/vCount)
- bomb_on  out  1  pixel lies on the armed bomb tile
- bomb_rgb  out  12  bomb colour
- explosion_on  out  1  pixel lies on the explosion cross
- explosion_rgb  out  12  explosion colour
- bomb_active  out  1  state is ARMED or EXPLODING
- bomb_tile_x, bomb_tile_y  out  TW each  latched bomb tile
- explode_pulse  out  1  one-cycle strobe on entry to EXPLODING
- bomberman_hit  out  1  player tile inside the cross while EXPLODING

## Operation
- The FSM has three states: IDLE, ARMED, and EXPLODING. A single down-counter cnt serves both timed states; its width is clog2 of the larger of FUSE_CYCLES and EXPLODE_CYCLES.
- IDLE -> ARMED: C=1 and game_over=0.
  - Latch bomb_tile_x = (b_x + 2^(TILE_BITS-1)) >> TILE_BITS, computed as an 11-bit sum so no overflow occurs; bomb_tile_y is computed the same way from b_y.
  - Load cnt = FUSE_CYCLES-1.
- ARMED: cnt decrements each cycle. At cnt==0 the FSM moves to EXPLODING, loads cnt = EXPLODE_CYCLES-1, and asserts explode_pulse for that cycle.
- EXPLODING: cnt decrements each cycle. At cnt==0 the FSM returns to IDLE.
- C outside IDLE is ignored. There is no queueing, and only one bomb exists at a time.
- game_over=1 forces IDLE synchronously from any state and clears cnt. explode_pulse is not generated on that transition.
- Pixel tile:
  - px = v_x >> TILE_BITS and py = v_y >> TILE_BITS.
  - dx = |px - bomb_tile_x| and dy = |py - bomb_tile_y|.
  - Each absolute difference is formed as larger minus smaller, so there is no wrap and the cross clips naturally at the grid edges.
- Pixel-layer conditions:
  - bomb_on = ARMED and dx==0 and dy==0.
  - explosion_on = EXPLODING and ((dy==0 and dx<=BLAST_RANGE) or (dx==0 and dy<=BLAST_RANGE)).
- bomberman_hit: the same cross test, applied to the player tile computed with the centre rounding used for the bomb latch, qualified by EXPLODING.
- bomb_rgb and explosion_rgb are held constant, except as noted under Configuration.

## Timing
- Reset values:
  - State IDLE and cnt=0.
  - bomb_tile_x and bomb_tile_y are 0.
  - bomb_on, explosion_on, bomb_active, explode_pulse, and bomberman_hit are all 0.
  - bomb_rgb=BOMB_COLOR and explosion_rgb=FIRE_COLOR.
- If C is sampled at edge n, bomb_active=1 from edge n+1.
- ARMED lasts exactly FUSE_CYCLES cycles. explode_pulse is high in the first EXPLODING cycle only.
- EXPLODING lasts exactly EXPLODE_CYCLES cycles, after which bomb_active=0.
- bomb_on, explosion_on, bomberman_hit, and the rgb outputs are registered: 1-cycle latency from v_x/v_y/b_x/b_y.
  - The top-level mux accepts this 1-pixel-clock skew.
- If C coincides with the ARMED->EXPLODING or EXPLODING->IDLE edge, C is ignored. A C pulse in the first IDLE cycle is accepted.
- When game_over and C are both high, game_over wins.
- Reset asserted mid-fuse returns the block to IDLE immediately. Outputs clear asynchronously.

## Configuration
- BOMB_BLINK_EN: when defined, bomb_rgb alternates between BOMB_COLOR and 12'hFFF while ARMED and cnt < FUSE_CYCLES/4, toggling each time cnt[22]==0 transitions.
- When BOMB_BLINK_EN is not defined, bomb_rgb is the constant BOMB_COLOR and no blink logic is built.

## Test plan
Parameters for the bench: FUSE_CYCLES=20, EXPLODE_CYCLES=8, BLAST_RANGE=2, TILE_BITS=5.
- Drop and lifecycle:
  - Stimulus: b_x=b_y=100, one C pulse.
  - Required: bomb_tile=(3,3), bomb_active high for 28 cycles, explode_pulse exactly once at cycle 21 after C.
- Pixel layers:
  - Stimulus: sweep v_x, v_y over the full 640x480 frame during ARMED, then during EXPLODING.
  - Required during ARMED: bomb_on only in pixels 96..127 x 96..127.
  - Required during EXPLODING: explosion_on on tiles x=1..5 at y=3 and tiles y=1..5 at x=3.
- Edge clipping:
  - Stimulus: b_x=b_y=0, one C pulse.
  - Required: tile (0,0); the cross covers x=0..2 and y=0..2 only, with no wrap to tile 19.
- Ignored requests:
  - Stimulus: C pulses during ARMED, during EXPLODING, and on the final EXPLODING cycle.
  - Required: no relatch and timing unchanged.
- Hit and game over:
  - Stimulus: player at tile (4,3) during EXPLODING.
  - Required: bomberman_hit=1.
  - Stimulus: then assert game_over.
  - Required: IDLE next cycle, and a C pulse with game_over high does not arm.
- Async reset:
  - Stimulus: Reset asserted mid-fuse.
  - Required: all outputs at their reset values before the next clock edge.
